pattern_detector: RTL
=====================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cfg_load, input, 1 bit: one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
REQ-006 SHALL have port cfg_pattern, input, MAX_LEN bits: target pattern; bit cfg_len-1 is the first-received bit and bit 0 the most recent.
REQ-007 SHALL have port cfg_len, input, $clog2(MAX_LEN+1) bits: active pattern length.
REQ-008 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 SHALL have port data_valid, input, 1 bit: qualifies data_in.
REQ-010 SHALL have port data_in, input, 1 bit: serial data bit.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_count.
REQ-012 SHALL have port detected, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-014 SHALL have port cfg_error, output, 1 bit: last loaded cfg_len was 0, 1 or greater than MAX_LEN.

Function
REQ-015 SHALL shift data_in into a MAX_LEN-bit history register only on cycles with data_valid=1; idle cycles leave all state unchanged.
REQ-016 SHALL keep a fill counter of valid bits received since the last clear, saturating at the active length.
REQ-017 SHALL declare a match on a data_valid beat when fill (including this beat) ≥ len and the len newest history bits equal cfg_pattern[len-1:0].
REQ-018 SHALL assert detected for exactly one cycle, the cycle after the matching beat (latency 1), and match_count SHALL update on the same edge.
REQ-019 SHALL leave fill unchanged after a match in overlap mode; in non-overlap mode fill SHALL clear to 0, so the next match needs len fresh bits.
REQ-020 SHALL saturate match_count at 2^CNT_W-1 with no wrap-around.
REQ-021 SHALL, when cnt_clr coincides with a match, set match_count to 1; cnt_clr alone SHALL set it to 0.
REQ-022 SHALL, on cfg_load, latch the configuration, clear fill, and ignore any data_valid beat in that same cycle; detected SHALL be 0 on the following cycle; match_count SHALL be unaffected.
REQ-023 SHALL, on a cfg_load with an illegal cfg_len, set cfg_error=1 and disable detection until a legal load, which SHALL clear cfg_error.
REQ-024 SHALL have no internal FSM beyond the fill counter; detection is disabled while the stored length is 0.

Reset
REQ-025 SHALL, with reset=1, clear the history, fill counter, stored pattern and stored length (giving detection disabled), detected, match_count and cfg_error to 0; reset SHALL take priority over cfg_load and cnt_clr.
REQ-026 SHALL, on reset mid-stream, discard any partial match; a match SHALL require a new cfg_load and len new bits.

Structure
REQ-027 SHALL place default MAX_LEN, default CNT_W and the length-width constant in a shared package, pattern_detector_pkg.
REQ-028 SHALL implement the history shift register and fill counter in one sub-module, pd_window; the compare, counter and config registers SHALL stay in the top level.

Verification
REQ-029 SHALL cover: len=3, pattern=3'b110, overlap=1, beats 1,1,0,1,1,0 -> detected after beats 3 and 6, match_count=2.
REQ-030 SHALL cover: len=4, pattern=4'b1010, beats 1,0,1,0,1,0 -> overlap=1 gives matches at beats 4 and 6 (count 2); overlap=0 gives a match at beat 4 only (count 1).
REQ-031 SHALL cover: the pattern 110 with data_valid=0 gaps of 3 cycles between beats -> a single detected pulse, exactly 1 cycle after the third valid beat.
REQ-032 SHALL cover: CNT_W=4, 20 overlapping matches -> match_count=15, held there; then cnt_clr plus a match in the same cycle -> match_count=1.
REQ-033 SHALL cover: cfg_load with cfg_len=0 -> cfg_error=1 and no detected for any stream; a legal reload -> cfg_error=0.
REQ-034 SHALL cover: reset asserted after 2 of 3 pattern bits, then the third bit -> no detected, all outputs 0.

Source files
------------

// File: rtl/pattern_detector_pkg.sv
// Shared defaults for the serial pattern detector and its window sub-block.
package pattern_detector_pkg;
   localparam int PD_MAX_LEN = 8;
   localparam int PD_CNT_W   = 16;
   localparam int PD_LEN_W   = $clog2(PD_MAX_LEN + 1);
endpackage

// File: rtl/pd_window.sv
// Serial history shift register and fill counter; both advance only on accepted beats.
module pd_window
   import pattern_detector_pkg::*;
#(
   parameter int MAX_LEN = PD_MAX_LEN,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_shift,
   input  logic               i_bit,
   input  logic               i_fill_clr,
   input  logic               i_match_clr,
   input  logic [LEN_W-1:0]   i_len,
   output logic [MAX_LEN-1:0] o_hist_next,
   output logic [LEN_W-1:0]   o_fill_next
);

   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W-1:0]   w_fill_next;

   // Look-ahead values include the beat being accepted this cycle.
   assign w_hist_next = {r_hist[MAX_LEN-2:0], i_bit};
   assign w_fill_next = (r_fill >= i_len) ? i_len : r_fill + LEN_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist <= '0;
      end else if (i_shift) begin
         r_hist <= w_hist_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_fill_clr) begin
         r_fill <= '0;
      end else if (i_shift) begin
         r_fill <= i_match_clr ? '0 : w_fill_next;
      end
   end

   assign o_hist_next = w_hist_next;
   assign o_fill_next = w_fill_next;

endmodule

// File: rtl/pattern_detector.sv
// Configurable serial bit-pattern detector with overlap control and saturating match counter.
module pattern_detector
   import pattern_detector_pkg::*;
#(
   parameter int MAX_LEN = PD_MAX_LEN,
   parameter int CNT_W   = PD_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         data_valid,
   input  logic                         data_in,
   input  logic                         cnt_clr,
   output logic                         detected,
   output logic [CNT_W-1:0]             match_count,
   output logic                         cfg_error
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0] r_pat;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_err;
   logic               r_det_p1;
   logic [CNT_W-1:0]   r_count;

   logic               w_shift;
   logic               w_len_ok;
   logic               w_match;
   logic [MAX_LEN-1:0] w_mask;
   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W-1:0]   w_fill_next;

   // A beat arriving with cfg_load is dropped so the new pattern starts from a clean window.
   assign w_shift  = data_valid & ~cfg_load;
   assign w_len_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));

   pd_window #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_window (
      .clk         (clk),
      .reset       (reset),
      .i_shift     (w_shift),
      .i_bit       (data_in),
      .i_fill_clr  (cfg_load),
      .i_match_clr (w_match & ~r_overlap),
      .i_len       (r_len),
      .o_hist_next (w_hist_next),
      .o_fill_next (w_fill_next)
   );

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
   end

   // An illegal load stores length 0, which is what disables detection.
   assign w_match = w_shift && (r_len != '0) && (w_fill_next >= r_len) &&
                    (((w_hist_next ^ r_pat) & w_mask) == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pat     <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         r_err     <= 1'b0;
      end else if (cfg_load) begin
         r_pat     <= cfg_pattern;
         r_len     <= w_len_ok ? cfg_len : '0;
         r_overlap <= cfg_overlap;
         r_err     <= ~w_len_ok;
      end
   end

   // Stage p1: registered match pulse and counter, both reflecting the beat of the previous cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_det_p1 <= 1'b0;
         r_count  <= '0;
      end else begin
         r_det_p1 <= w_match;
         if (cnt_clr) begin
            r_count <= w_match ? CNT_W'(1) : '0;
         end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign detected    = r_det_p1;
   assign match_count = r_count;
   assign cfg_error   = r_err;

endmodule
